// File: rtl/braille_timer_sched_pkg.sv
// Shared types and helpers for the trainer timer scheduler and its arbiter.
package braille_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESTART = 2'd1,
    COUNT   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_SEC_W   = 4;
  localparam int MAX_REQ     = 8;

  function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/braille_timer_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW:0] cand;

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (IW + 1)'(k);
      if (cand >= (IW + 1)'(N)) cand = cand - (IW + 1)'(N);
      if (req[cand[IW-1:0]]) begin
        idx   = cand[IW-1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/braille_timer_sched.sv
// Grants the shared 1 s timer to one requester at a time and counts its delay.
module braille_timer_sched
  import braille_timer_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int SEC_W   = DEF_SEC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*SEC_W-1:0] req_secs,
  input  logic                     tick_1s,
  output logic                     timer_rst_n,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [SEC_W-1:0]         secs_left
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             state_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [IDX_W-1:0]   ptr_reg;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic [IDX_W-1:0]   next_ptr;
  logic [SEC_W-1:0]   pick_secs;
  logic [NUM_REQ-1:0] pick_oh;
  logic               owner_req;
  logic [SEC_W-1:0]   secs_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_secs
    assign secs_arr[gi] = req_secs[gi*SEC_W +: SEC_W];
  end

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req   (req),
    .ptr   (ptr_reg),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign pick_secs = secs_arr[arb_idx];
  assign pick_oh   = NUM_REQ'(onehot(3'(arb_idx)));
  assign owner_req = req[idx_reg];
  assign next_ptr  = (idx_reg == IDX_W'(NUM_REQ - 1)) ? '0 : idx_reg + IDX_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      ptr_reg     <= '0;
      gnt         <= '0;
      done        <= '0;
      busy        <= 1'b0;
      secs_left   <= '0;
      timer_rst_n <= 1'b1;
    end else begin
      done        <= '0;
      timer_rst_n <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (arb_valid) begin
            idx_reg <= arb_idx;
            gnt     <= pick_oh;
            busy    <= 1'b1;
            if (pick_secs == '0) begin
              state_reg <= DONE;
              done      <= pick_oh;
              secs_left <= '0;
            end else begin
              state_reg   <= RESTART;
              timer_rst_n <= 1'b0;
              secs_left   <= pick_secs;
            end
          end
        end
        RESTART, COUNT: begin
          // Dropping the owner's request aborts, even against a coincident expiry.
          if (!owner_req) begin
            state_reg <= IDLE;
            gnt       <= '0;
            busy      <= 1'b0;
            secs_left <= '0;
            ptr_reg   <= next_ptr;
          end else if (state_reg == RESTART) begin
            state_reg <= COUNT;
          end else if (tick_1s && secs_left != '0) begin
            secs_left <= secs_left - SEC_W'(1);
            if (secs_left == SEC_W'(1)) begin
              state_reg <= DONE;
              done      <= gnt;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
          gnt       <= '0;
          busy      <= 1'b0;
          secs_left <= '0;
          ptr_reg   <= next_ptr;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_braille_timer_sched.sv
// Randomised and directed checks of braille_timer_sched against a grant-level model.
module tb_braille_timer_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [15:0] req_secs = '0;
  logic        tick_1s = 1'b0;
  logic        timer_rst_n;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic [3:0]  secs_left;

  int checks = 0;
  int failures = 0;

  braille_timer_sched dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_secs    (req_secs),
    .tick_1s     (tick_1s),
    .timer_rst_n (timer_rst_n),
    .gnt         (gnt),
    .done        (done),
    .busy        (busy),
    .secs_left   (secs_left)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: tracks who owns the timer, how many seconds remain,
  // and whether the owner is in its restart cycle or finishing cycle.
  int   m_owner = -1;
  int   m_left = 0;
  int   m_ptr = 0;
  bit   m_restart = 0;
  bit   m_fin = 0;
  int   m_c;
  bit   m_found;
  logic [3:0] exp_gnt = '0, exp_done = '0, exp_secs = '0;
  logic       exp_busy = 1'b0, exp_trst_n = 1'b1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1; m_left = 0; m_ptr = 0; m_restart = 0; m_fin = 0;
    end else if (m_fin) begin
      $display("txn: requester %0d completed", m_owner);
      m_ptr = (m_owner + 1) % 4; m_owner = -1; m_fin = 0; m_left = 0;
    end else if (m_owner < 0) begin
      m_found = 0;
      for (int k = 0; k < 4; k++) begin
        m_c = (m_ptr + k) % 4;
        if (!m_found && req[m_c]) begin
          m_found = 1;
          m_owner = m_c;
          m_left  = int'(req_secs[m_c*4 +: 4]);
          if (m_left == 0) m_fin = 1; else m_restart = 1;
        end
      end
    end else if (!req[m_owner]) begin
      $display("txn: requester %0d aborted", m_owner);
      m_ptr = (m_owner + 1) % 4; m_owner = -1; m_left = 0; m_restart = 0;
    end else if (m_restart) begin
      m_restart = 0;
    end else if (tick_1s) begin
      m_left = m_left - 1;
      if (m_left == 0) m_fin = 1;
    end
    exp_gnt    = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
    exp_done   = m_fin ? exp_gnt : 4'd0;
    exp_busy   = (m_owner >= 0);
    exp_trst_n = !m_restart;
    exp_secs   = 4'(m_left);
  end

  // Per-cycle comparison plus a log of grant order as seen on the DUT.
  int   dut_order[$];
  logic [3:0] prev_gnt = '0;
  always @(negedge clk) begin
    if (!rst) begin
      check_val("gnt", 32'(gnt), 32'(exp_gnt));
      check_val("done", 32'(done), 32'(exp_done));
      check_val("busy", 32'(busy), 32'(exp_busy));
      check_val("timer_rst_n", 32'(timer_rst_n), 32'(exp_trst_n));
      check_val("secs_left", 32'(secs_left), 32'(exp_secs));
      if (prev_gnt == 4'd0 && gnt != 4'd0)
        for (int i = 0; i < 4; i++) if (gnt[i]) dut_order.push_back(i);
    end
    prev_gnt = gnt;
  end

  task automatic run(input int n, input int period);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      tick_1s = (period > 0) && ((c % period) == period - 1);
      for (int i = 0; i < 4; i++) if (exp_done[i]) req[i] = 1'b0;
    end
    @(negedge clk);
    tick_1s = 1'b0;
    for (int i = 0; i < 4; i++) if (exp_done[i]) req[i] = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("rst_gnt", 32'(gnt), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_secs", 32'(secs_left), 32'd0);
    check_val("rst_trst_n", 32'(timer_rst_n), 32'd1);
    req = '0; tick_1s = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int k_done;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_val("init_gnt", 32'(gnt), 32'd0);
    check_val("init_trst_n", 32'(timer_rst_n), 32'd1);

    // Single request, 3 s, tick every 20 cycles.
    @(negedge clk);
    req_secs[8 +: 4] = 4'd3; req[2] = 1'b1;
    @(negedge clk);
    check_val("single_gnt_c1", 32'(gnt), 32'h4);
    check_val("single_trst_c1", 32'(timer_rst_n), 32'd0);
    check_val("single_secs_c1", 32'(secs_left), 32'd3);
    run(80, 20);

    // Reset while a grant is counting.
    req_secs[12 +: 4] = 4'd9; req[3] = 1'b1;
    run(20, 4);
    pulse_reset();

    // Round robin from pointer 0 with 0,1,3 pending, then 0 re-requests.
    dut_order.delete();
    req_secs = 16'h1111; req = 4'b1011;
    run(10, 3);
    req[0] = 1'b1;
    run(40, 3);
    check_val("rr_count", 32'(dut_order.size()), 32'd4);
    if (dut_order.size() >= 4) begin
      check_val("rr_0", 32'(dut_order[0]), 32'd0);
      check_val("rr_1", 32'(dut_order[1]), 32'd1);
      check_val("rr_2", 32'(dut_order[2]), 32'd3);
      check_val("rr_3", 32'(dut_order[3]), 32'd0);
    end

    // Zero delay completes without a restart.
    @(negedge clk);
    req_secs[4 +: 4] = 4'd0; req[1] = 1'b1; tick_1s = 1'b0;
    @(negedge clk);
    check_val("zero_done_c1", 32'(done), 32'h2);
    check_val("zero_trst_c1", 32'(timer_rst_n), 32'd1);
    req[1] = 1'b0;
    run(4, 0);

    // Abort after two ticks with a tick coincident with the drop.
    pulse_reset();
    req_secs[0 +: 4] = 4'd5; req[0] = 1'b1;
    repeat (3) @(negedge clk);
    tick_1s = 1'b1; @(negedge clk); tick_1s = 1'b0;
    repeat (2) @(negedge clk);
    tick_1s = 1'b1; @(negedge clk); tick_1s = 1'b0;
    repeat (2) @(negedge clk);
    check_val("abort_secs_before", 32'(secs_left), 32'd3);
    tick_1s = 1'b1; req[0] = 1'b0; req_secs[4 +: 4] = 4'd2; req[1] = 1'b1;
    @(negedge clk);
    tick_1s = 1'b0;
    check_val("abort_gnt", 32'(gnt), 32'd0);
    check_val("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    check_val("abort_next_gnt", 32'(gnt), 32'h2);
    run(20, 2);

    // Max delay with tick held high: restart-cycle tick ignored, 15 counted.
    @(negedge clk);
    tick_1s = 1'b1; req_secs[12 +: 4] = 4'd15; req[3] = 1'b1;
    k_done = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 2) check_val("max_secs_c2", 32'(secs_left), 32'd15);
      if (done[3]) begin k_done = k; break; end
    end
    check_val("max_done_cycle", 32'(k_done), 32'd17);
    req[3] = 1'b0; tick_1s = 1'b0;
    run(4, 0);

    // Randomised traffic, including aborts and req_secs churn.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      tick_1s = ($urandom_range(3) == 0);
      if ($urandom_range(15) == 0) req_secs = 16'($urandom);
      for (int i = 0; i < 4; i++) begin
        if (exp_done[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(7) == 0) begin
          req[i] = 1'b1;
          req_secs[i*4 +: 4] = ($urandom_range(9) == 0) ? 4'd15 : 4'($urandom_range(3));
        end else if (req[i] && $urandom_range(63) == 0) req[i] = 1'b0;
      end
    end
    req = '0; tick_1s = 1'b0;
    run(4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
